// File: rtl/project_switch_ctrl.sv
// project_switch_ctrl: sequences glitch-safe I/O time-sharing between NUM_PROJ user projects.
//
// Optional feature macro: PROJECT_SWITCH_LOCK_EN (adds sel_lock_i, which blocks new requests).
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   sel_req_i        requested project index
//   sel_req_valid_i  request valid
//   sel_lock_i       (PROJECT_SWITCH_LOCK_EN only) 1 = refuse new requests
//   sel_req_ready_o  controller accepts a request (RUN only)
//   active_sel_o     output mux select
//   proj_rst_n_o     per-project active-low resets, at most one bit high
//   out_gate_o       1 = shared outputs forced to 0
//   busy_o           high whenever not in RUN
//   switch_done_o    one-cycle pulse when a switch or no-op request completes
//   sel_err_o        one-cycle pulse when an out-of-range request is accepted
module project_switch_ctrl #(
    parameter int NUM_PROJ          = 2,
    parameter int SEL_W             = $clog2(NUM_PROJ),
    parameter int SETTLE_CYCLES     = 4,
    parameter int RESET_HOLD_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEL_W-1:0]    sel_req_i,
    input  logic                sel_req_valid_i,
`ifdef PROJECT_SWITCH_LOCK_EN
    input  logic                sel_lock_i,
`endif
    output logic                sel_req_ready_o,
    output logic [SEL_W-1:0]    active_sel_o,
    output logic [NUM_PROJ-1:0] proj_rst_n_o,
    output logic                out_gate_o,
    output logic                busy_o,
    output logic                switch_done_o,
    output logic                sel_err_o
);
    localparam int CNT_MAX = (SETTLE_CYCLES > RESET_HOLD_CYCLES) ? SETTLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [SEL_W:0] NP = (SEL_W + 1)'(NUM_PROJ);
    localparam logic [NUM_PROJ-1:0] ONE = NUM_PROJ'(1);

    typedef enum logic [2:0] {INIT_HOLD, RUN, GATE, HOLD, RELEASE} state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [SEL_W-1:0]     pend_q;
    logic [SEL_W-1:0]     sel_q;
    logic [NUM_PROJ-1:0]  rstn_q;
    logic                 gate_q;
    logic                 busy_q;
    logic                 ready_q;
    logic                 done_q;
    logic                 err_q;
    logic                 lock;
    logic                 accept;
    logic                 init_done;

`ifdef PROJECT_SWITCH_LOCK_EN
    assign lock = sel_lock_i;
`else
    assign lock = 1'b0;
`endif

    assign accept = sel_req_valid_i & ready_q & ~lock;
    // The counter leaves reset at 0, so the power-on window is armed on the first
    // clock (loaded with HOLD_LD) and ends when it has decayed to 1.
    assign init_done = (RESET_HOLD_CYCLES == 1) || (cnt_q == CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT_HOLD;
            cnt_q   <= '0;
            pend_q  <= '0;
            sel_q   <= '0;
            rstn_q  <= '0;
            gate_q  <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                INIT_HOLD: begin
                    if (init_done) begin
                        state_q <= RELEASE;
                        cnt_q   <= SETTLE_LD;
                        rstn_q  <= ONE << sel_q;
                    end else begin
                        cnt_q <= (cnt_q == '0) ? HOLD_LD : cnt_q - CNT_ONE;
                    end
                end
                RUN: begin
                    ready_q <= ~lock;
                    if (accept) begin
                        if (sel_req_i == sel_q) begin
                            done_q <= 1'b1;
                        end else if ({1'b0, sel_req_i} >= NP) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= GATE;
                            cnt_q   <= SETTLE_LD;
                            pend_q  <= sel_req_i;
                            gate_q  <= 1'b1;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                end
                GATE: begin
                    if (cnt_q == '0) begin
                        state_q <= HOLD;
                        cnt_q   <= HOLD_LD;
                        sel_q   <= pend_q;
                        rstn_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= RELEASE;
                        cnt_q   <= SETTLE_LD;
                        rstn_q  <= ONE << sel_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (cnt_q == '0) begin
                        state_q <= RUN;
                        gate_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= ~lock;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: state_q <= INIT_HOLD;
            endcase
        end
    end

    assign sel_req_ready_o = ready_q;
    assign active_sel_o    = sel_q;
    assign proj_rst_n_o    = rstn_q;
    assign out_gate_o      = gate_q;
    assign busy_o          = busy_q;
    assign switch_done_o   = done_q;
    assign sel_err_o       = err_q;
endmodule

// File: doc/project_switch_ctrl.md
Name: project_switch_ctrl

Overview:
- Sequences time-sharing of the chip I/O between NUM_PROJ user projects that sit behind a shared output mux.
- Owns the active-project select, the per-project resets and an output gate.
- Performs a glitch-safe switchover: gate outputs, hold every project in reset, then release the newly selected one.
- Requests arrive over a valid/ready handshake from the config interface.

Parameters:
- NUM_PROJ, 2, number of projects sharing the I/O; legal range 2..8.
- SEL_W, $clog2(NUM_PROJ), select width; derived, not overridden.
- SETTLE_CYCLES, 4, cycles the gate is held before a project goes into reset and after it is released; must be >=1.
- RESET_HOLD_CYCLES, 16, cycles every project is held in reset during a switch and after power-on; must be >=1.

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- sel_req  in  SEL_W  requested project index.
- sel_req_valid  in  1  request valid.
- sel_req_ready  out  1  controller accepts a request.
- active_sel  out  SEL_W  drives the output mux select; registered.
- proj_rst_n  out  NUM_PROJ  per-project active-low reset; registered.
- out_gate  out  1  1 = mux forces uo_out/uio_out/uio_oe to 0.
- busy  out  1  high whenever the FSM is not in RUN.
- switch_done  out  1  one-cycle pulse when a switch or no-op completes.
- sel_err  out  1  one-cycle pulse when an out-of-range request is accepted.

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-low, ports named clk and rst_n.
- Reset values:
  - active_sel=0, proj_rst_n=all 0, out_gate=1, busy=1.
  - sel_req_ready=0, switch_done=0, sel_err=0.
  - FSM=INIT_HOLD, counter=0.
- All outputs are registered.
- FSM states:
  - INIT_HOLD: all resets asserted, gate=1. Lasts RESET_HOLD_CYCLES cycles after rst_n deasserts, then goes to RELEASE.
  - RUN: proj_rst_n[active_sel]=1, all others 0; out_gate=0; busy=0; sel_req_ready=1.
  - GATE: out_gate=1; old project stays out of reset. Lasts SETTLE_CYCLES, then HOLD.
  - HOLD: proj_rst_n=all 0; active_sel is loaded with the pending select on entry. Lasts RESET_HOLD_CYCLES, then RELEASE.
  - RELEASE: proj_rst_n[active_sel]=1; out_gate=1. Lasts SETTLE_CYCLES, then RUN. switch_done pulses in the first RUN cycle.
- Handshake:
  - A request is accepted on the edge where sel_req_valid & sel_req_ready are both high.
  - sel_req_ready is 0 in every state except RUN.
  - sel_req is captured into a pending register on acceptance; the requester may change it afterwards.
- Request outcomes on acceptance at edge k:
  - sel_req == active_sel: no-op. Stay in RUN, switch_done=1 in cycle k+1, no reset or gate activity.
  - sel_req >= NUM_PROJ: rejected. sel_err=1 in cycle k+1, stay in RUN, nothing else changes.
  - Otherwise: GATE from cycle k+1. First RUN cycle is k+1+2*SETTLE_CYCLES+RESET_HOLD_CYCLES (k+25 with defaults).
- Counter: a single down-counter sized for max(SETTLE_CYCLES, RESET_HOLD_CYCLES). It is loaded on each state entry, and the state exits when the counter reaches 0.
- Boundary conditions:
  - Back-to-back valid requests: the second is not accepted until RUN. The first RUN cycle asserts ready and may accept immediately.
  - switch_done and a new acceptance may coincide in the first RUN cycle.
  - rst_n asserted mid-switch: async return to reset values, then INIT_HOLD with active_sel=0.
  - At no time may two bits of proj_rst_n be 1 simultaneously.
  - out_gate is 1 on every cycle in which active_sel changes.

Optional Feature:
- Macro: PROJECT_SWITCH_LOCK_EN.
- When defined:
  - Adds input port sel_lock (1 bit).
  - While sel_lock=1, sel_req_ready is forced to 0 even in RUN.
  - Asserting sel_lock during a switch does not abort the switch; it blocks only new acceptances.
- When not defined: the port is absent and behaviour equals sel_lock=0.

Test Plan:
- Release rst_n at cycle 0:
  - proj_rst_n=00 for cycles 0..15, proj_rst_n=01 from cycle 16, out_gate=1 until cycle 19.
  - RUN at cycle 20 with out_gate=0, ready=1, switch_done=1.
- In RUN with active_sel=0, request sel_req=1 accepted at edge k:
  - GATE k+1..k+4, HOLD k+5..k+20 with proj_rst_n=00 and active_sel=1 from k+5.
  - RELEASE k+21..k+24 with proj_rst_n=10; RUN at k+25 with switch_done pulse.
- Request sel_req=active_sel=1 -> switch_done pulse at k+1; busy, out_gate and proj_rst_n unchanged.
- NUM_PROJ=3, request sel_req=3 -> sel_err pulse at k+1; active_sel unchanged; ready stays 1.
- Hold sel_req_valid high through a switch:
  - ready=0 from k+1 to k+24.
  - The second request is accepted at k+25; assert no overlapping proj_rst_n bits throughout.
- Assert rst_n low during HOLD:
  - Outputs return to reset values within the same cycle (async).
  - On release, the INIT_HOLD sequence completes with active_sel=0.
  - With PROJECT_SWITCH_LOCK_EN defined, sel_lock=1 in RUN keeps ready=0 and ignores valid requests.
